// File: rtl/top_k_tracker_if.sv
// top_k_tracker_if: sample stream in, ranked list and selected rank out.
interface top_k_tracker_if #(
  parameter int DATA_WIDTH = 32,
  parameter int K = 4,
  parameter int RW = $clog2(K),
  parameter int CW = $clog2(K + 1)
);
  logic din_valid;
  logic [DATA_WIDTH-1:0] din;
  logic clear;
  logic [RW-1:0] rank_sel;
  logic [DATA_WIDTH-1:0] dout;
  logic [K*DATA_WIDTH-1:0] dout_all;
  logic [CW-1:0] count;
  logic full;
  modport master (output din_valid, din, clear, rank_sel, input dout, dout_all, count, full);
  modport slave (input din_valid, din, clear, rank_sel, output dout, dout_all, count, full);
endinterface

// File: rtl/top_k_tracker.sv
// top_k_tracker: keeps the K best (largest, or smallest in min mode) samples seen
// in a sorted register array; one sample absorbed per cycle.
module top_k_tracker #(
  parameter int DATA_WIDTH = 32,
  parameter int K = 4,
  parameter int MODE_MIN = 0,
  parameter int RW = $clog2(K),
  parameter int CW = $clog2(K + 1)
) (
  input logic clk,
  input logic resetn,
  top_k_tracker_if.slave bus
);
  logic [K-1:0][DATA_WIDTH-1:0] slot, nxt;
  logic [K-1:0] occ, go;
  // go is a thermometer: din lands at the first rank where it beats the entry or finds it empty
  for (genvar i = 0; i < K; i++) begin : g_rank
    assign go[i] = !occ[i] || (MODE_MIN != 0 ? bus.din < slot[i] : bus.din > slot[i]);
    if (i == 0) begin : g_head
      assign nxt[i] = go[i] ? bus.din : slot[i];
    end else begin : g_tail
      assign nxt[i] = !go[i] ? slot[i] : go[i-1] ? slot[i-1] : bus.din;
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      slot <= '0;
      occ <= '0;
    end else if (bus.clear) begin
      slot <= '0;
      occ <= '0;
    end else if (bus.din_valid && go[K-1]) begin
      slot <= nxt;
      occ <= {occ[K-2:0], 1'b1};
    end
  end
  // empty slots are held at 0, so the array can be exported unmasked
  assign bus.dout_all = slot;
  assign bus.dout = int'(bus.rank_sel) < K ? slot[bus.rank_sel] : '0;
  assign bus.count = CW'($countones(occ));
  assign bus.full = occ[K-1];
endmodule

// File: doc/top_k_tracker.md
Name: top_k_tracker

Overview:
- Streaming tracker that keeps the K largest values (or K smallest in min mode) sampled so far, kept in a sorted register array.
- Exposes the full ranked list plus one run-time selectable rank.
- Generalises the team's second-largest tracker in four ways: parametrised depth K, max/min mode, an input valid qualifier, and a synchronous clear.
- Sits on a datapath monitor bus, feeding statistics/CSR readback.

Parameters:
- DATA_WIDTH, 32, width of each unsigned sample.
- K, 4, number of ranked slots tracked. Legal range 2..16.
- MODE_MIN, 0. 0 tracks the largest values; 1 tracks the smallest.
- RW, $clog2(K), width of rank_sel.
- CW, $clog2(K+1), width of count.

Ports:
- clk  in  1  rising-edge clock.
- resetn  in  1  asynchronous active-low reset.
- din_valid  in  1  qualifies din for the current cycle.
- din  in  DATA_WIDTH  unsigned sample.
- clear  in  1  synchronous flush of all tracked values.
- rank_sel  in  RW  rank to present on dout. 0 = best, K-1 = K-th best.
- dout  out  DATA_WIDTH  value at rank rank_sel; 0 if that slot is empty.
- dout_all  out  K*DATA_WIDTH  all ranks concatenated, rank 0 in the LSBs; empty slots read 0.
- count  out  CW  number of occupied slots, saturating at K.
- full  out  1  high when count == K.

Behaviour:
- Reset: resetn low asynchronously clears all slots, valid bits and count. dout=0, dout_all=0, count=0, full=0. Deassertion is synchronised externally.
- State: slot[0..K-1] plus occ[0..K-1]. occ is thermometer-coded: occupied slots are always a contiguous prefix from rank 0.
- "Better" comparison: MODE_MIN=0 uses a > b; MODE_MIN=1 uses a < b. All comparisons are unsigned, full width.
- Insertion (din_valid=1, clear=0), single cycle:
  - pos = number of occupied slots s for which NOT (din better than s). Equal values therefore rank after the existing entry.
  - If pos < K: slot[pos] <= din; slots pos..K-2 shift to pos+1..K-1; slot[K-1] is dropped if it was occupied; count increments, saturating at K.
  - If pos == K (full, and din not better than slot[K-1]): no change.
- Duplicates are separate candidates. Example with K=2: inputs 5, 5 give ranks {5,5}.
- din_valid=0: all state holds.
- Latency: a sample accepted at edge n is visible on dout, dout_all and count after edge n (registered state). dout is a combinational mux of the registered slots by rank_sel, so a rank_sel change takes effect in the same cycle.
- clear=1 at an edge: empties all slots (values forced to 0, occ=0, count=0).
  - clear has priority over a simultaneous din_valid; that din is discarded.
  - Outputs read 0 from the next cycle.
- Empty slots: dout/dout_all report 0 for every rank r >= count, including MODE_MIN=1, where 0 must not be mistaken for a tracked value. Consumers use count for that.
- rank_sel >= K (only possible when K is not a power of 2): dout=0.
- Compatibility: K=2, MODE_MIN=0, din_valid=1, rank_sel=1, clear=~resetn_sync reproduces the legacy second-largest output.
- Implementation: K parallel comparators plus a priority/shift network; no multi-cycle sort and no backpressure. Every valid sample is absorbed in one cycle.

Test Plan:
- K=4, MODE_MIN=0, stream 7,3,9,3,1 -> dout_all ranks {9,7,3,3}; count=4; full=1; 1 is dropped.
- K=4, single input 42 -> count=1; rank0=42; ranks 1..3 read 0. rank_sel=1 -> dout=0; rank_sel=0 -> dout=42 in the same cycle.
- K=4, MODE_MIN=1, stream 8,2,0xFFFFFFFF,2,5 -> ranks {2,2,5,8}; 0xFFFFFFFF is evicted.
- Stream 10,20 with din_valid=0 on 20, then 15 valid -> ranks {15,10,0,0}; count=2.
- Fill K=4 with 4,3,2,1, then clear=1 with din_valid=1, din=99 in the same cycle -> next cycle count=0, all ranks 0, 99 not captured. The next valid 6 gives rank0=6.
- resetn pulsed low mid-stream between clock edges -> outputs go to 0 immediately, without waiting for a clock edge. After release, stream 0,0 -> count=2 and ranks {0,0}.
